// File: rtl/mcac_tdm_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mcac_tdm_tx_if
// Brief    : Code-word write port from the mcac core into the TDM transmitter.
// Revision : 1.0
// ============================================================================
interface mcac_tdm_tx_if #(
    parameter int unsigned CHANNELS = 32,
    parameter int unsigned WORD_W   = 8
);
    localparam int unsigned c_chan_w = $clog2(CHANNELS);

    logic                wr_valid;
    logic                wr_ready;
    logic [c_chan_w-1:0] wr_chan;
    logic [WORD_W-1:0]   wr_data;

    modport master (output wr_valid, output wr_chan, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_chan, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/mcac_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : mcac_tdm_tx
// Brief    : Double-banked frame buffer shifted MSB-first onto a serial TDM line.
// Revision : 1.0
// ============================================================================
module mcac_tdm_tx #(
    parameter int unsigned       CHANNELS  = 32,
    parameter int unsigned       WORD_W    = 8,
    parameter logic [WORD_W-1:0] IDLE_CODE = WORD_W'(8'hFF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fs,
    input  logic               bit_en,
    mcac_tdm_tx_if.slave       wr,
    output logic               sdo,
    output logic               sdo_en,
    output logic               frame_done,
    output logic               underrun,
    output logic               sync_err
);
    localparam int unsigned c_chan_w     = $clog2(CHANNELS);
    localparam int unsigned c_frame_bits = CHANNELS * WORD_W;
    localparam int unsigned c_cnt_w      = $clog2(c_frame_bits);
    localparam int unsigned c_bit_w      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_frame_bits - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic                        bank_sel_q, bank_sel_d;
    logic [1:0][CHANNELS-1:0]    mask_q, mask_d;
    logic [CHANNELS-1:0]         snap_q, snap_d;
    logic [c_cnt_w-1:0]          bit_cnt_q, bit_cnt_d;
    logic                        sdo_q, sdo_d;
    logic                        sdo_en_q, sdo_en_d;
    logic                        frame_done_q, frame_done_d;
    logic                        underrun_q, underrun_d;
    logic                        sync_err_q, sync_err_d;
    logic                        wr_ready_q;

    logic [WORD_W-1:0]           bank_mem [2][CHANNELS];

    logic                        wr_fire;
    logic                        wr_bank;
    logic [c_cnt_w-1:0]          cnt_inc;
    logic                        rd_bank;
    logic [CHANNELS-1:0]         rd_mask;
    logic [c_chan_w-1:0]         rd_slot;
    logic [c_bit_w-1:0]          rd_bit;
    logic [WORD_W-1:0]           rd_word;
    logic                        rd_bit_val;

    // A write coinciding with fs must target the bank that becomes the write bank.
    assign wr_fire = wr.wr_valid & wr_ready_q;
    assign wr_bank = fs ? ~bank_sel_q : bank_sel_q;

    // At fs the frame is not yet swapped, so slot 0 comes from the current write bank.
    always_comb begin
        cnt_inc = bit_cnt_q + 1'b1;
        if (fs) begin
            rd_bank = bank_sel_q;
            rd_mask = mask_q[bank_sel_q];
            rd_slot = '0;
            rd_bit  = c_bit_w'(WORD_W - 1);
        end else begin
            rd_bank = ~bank_sel_q;
            rd_mask = snap_q;
            rd_slot = c_chan_w'(cnt_inc / WORD_W);
            rd_bit  = c_bit_w'(WORD_W - 1 - (cnt_inc % WORD_W));
        end
        rd_word    = rd_mask[rd_slot] ? bank_mem[rd_bank][rd_slot] : IDLE_CODE;
        rd_bit_val = rd_word[rd_bit];
    end

    always_comb begin
        state_d      = state_q;
        bank_sel_d   = bank_sel_q;
        mask_d       = mask_q;
        snap_d       = snap_q;
        bit_cnt_d    = bit_cnt_q;
        sdo_d        = sdo_q;
        sdo_en_d     = sdo_en_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        sync_err_d   = 1'b0;

        if (fs) begin
            bank_sel_d          = ~bank_sel_q;
            snap_d              = mask_q[bank_sel_q];
            underrun_d          = ~&mask_q[bank_sel_q];
            mask_d[~bank_sel_q] = '0;
            sync_err_d          = (state_q == ST_SHIFT);
            state_d             = ST_SHIFT;
            bit_cnt_d           = '0;
            sdo_en_d            = 1'b1;
            sdo_d               = rd_bit_val;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (bit_en) begin
                        if (bit_cnt_q == c_last) begin
                            state_d      = ST_IDLE;
                            bit_cnt_d    = '0;
                            sdo_en_d     = 1'b0;
                            sdo_d        = 1'b0;
                            frame_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = cnt_inc;
                            sdo_d     = rd_bit_val;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Applied after the fs clear so a same-cycle write keeps its mask bit.
        if (wr_fire) begin
            mask_d[wr_bank][wr.wr_chan] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bank_sel_q   <= 1'b0;
            mask_q       <= '0;
            snap_q       <= '0;
            bit_cnt_q    <= '0;
            sdo_q        <= 1'b0;
            sdo_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            sync_err_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
            mask_q       <= mask_d;
            snap_q       <= snap_d;
            bit_cnt_q    <= bit_cnt_d;
            sdo_q        <= sdo_d;
            sdo_en_q     <= sdo_en_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            sync_err_q   <= sync_err_d;
            wr_ready_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[wr_bank][wr.wr_chan] <= wr.wr_data;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign sdo         = sdo_q;
    assign sdo_en      = sdo_en_q;
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
    assign sync_err    = sync_err_q;
endmodule
`default_nettype wire

// File: tb/tb_mcac_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcac_tdm_tx
// Brief    : Directed scoreboard bench for the TDM serial transmitter.
// Revision : 1.0
// ============================================================================
module tb_mcac_tdm_tx;
    localparam int unsigned CH   = 32;
    localparam int unsigned WW   = 8;
    localparam int unsigned FB   = CH * WW;
    localparam logic [WW-1:0] IDLE = 8'hFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fs = 1'b0;
    logic bit_en = 1'b0;
    logic sdo, sdo_en, frame_done, underrun, sync_err;

    mcac_tdm_tx_if #(.CHANNELS(CH), .WORD_W(WW)) wr_if ();

    mcac_tdm_tx #(.CHANNELS(CH), .WORD_W(WW), .IDLE_CODE(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .fs         (fs),
        .bit_en     (bit_en),
        .wr         (wr_if),
        .sdo        (sdo),
        .sdo_en     (sdo_en),
        .frame_done (frame_done),
        .underrun   (underrun),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] pend_data [CH];
    logic [CH-1:0] pend_mask = '0;
    bit            exp_q [$];
    logic          in_frame = 1'b0;
    int            pos = 0;
    int            frame_no = 0;
    logic          cur_bit = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " sdo"},        sdo,             1'b0);
        chk({tag, " sdo_en"},     sdo_en,          1'b0);
        chk({tag, " frame_done"}, frame_done,      1'b0);
        chk({tag, " underrun"},   underrun,        1'b0);
        chk({tag, " sync_err"},   sync_err,        1'b0);
        chk({tag, " wr_ready"},   wr_if.wr_ready,  1'b0);
    endtask

    // One clock of stimulus; the model predicts every output for the following cycle.
    task automatic cycle(input logic f, input logic be, input logic wv,
                         input int ch, input logic [WW-1:0] wd);
        logic exp_sync, exp_under, exp_fd;
        logic [WW-1:0] w;
        fs = f;
        bit_en = be;
        wr_if.wr_valid = wv;
        wr_if.wr_chan  = ch[4:0];
        wr_if.wr_data  = wd;
        @(posedge clk);
        #1;
        fs = 1'b0;
        bit_en = 1'b0;
        wr_if.wr_valid = 1'b0;
        exp_sync = 1'b0;
        exp_under = 1'b0;
        exp_fd = 1'b0;
        if (f) begin
            exp_sync  = in_frame;
            exp_under = ~&pend_mask;
            exp_q.delete();
            for (int s = 0; s < CH; s++) begin
                w = pend_mask[s] ? pend_data[s] : IDLE;
                for (int b = WW - 1; b >= 0; b--) exp_q.push_back(w[b]);
            end
            pend_mask = '0;
            in_frame = 1'b1;
            pos = 0;
            frame_no++;
            cur_bit = exp_q.pop_front();
        end else if (be && in_frame) begin
            if (pos == FB - 1) begin
                in_frame = 1'b0;
                exp_fd = 1'b1;
                cur_bit = 1'b0;
            end else begin
                pos++;
                cur_bit = exp_q.pop_front();
            end
        end
        if (wv) begin
            pend_data[ch] = wd;
            pend_mask[ch] = 1'b1;
        end
        chk($sformatf("sdo fr%0d slot%0d bit%0d", frame_no, pos / WW, pos % WW), sdo, cur_bit);
        chk($sformatf("sdo_en fr%0d pos%0d", frame_no, pos), sdo_en, in_frame);
        chk($sformatf("frame_done fr%0d pos%0d", frame_no, pos), frame_done, exp_fd);
        chk($sformatf("underrun fr%0d", frame_no), underrun, exp_under);
        chk($sformatf("sync_err fr%0d", frame_no), sync_err, exp_sync);
        chk("wr_ready", wr_if.wr_ready, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic bits(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 0, '0);
            if (gap > 1) idle(gap - 1);
        end
    endtask

    task automatic write(input int ch, input logic [WW-1:0] d);
        cycle(1'b0, 1'b0, 1'b1, ch, d);
    endtask

    task automatic frame_sync();
        cycle(1'b1, 1'b0, 1'b0, 0, '0);
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_chan  = '0;
        wr_if.wr_data  = '0;

        // Reset held low for three clocks, then released.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all_zero($sformatf("reset clk%0d", i));
        end
        reset = 1'b1;
        chk("wr_ready at release", wr_if.wr_ready, 1'b0);
        idle(1);

        // First frame after reset: all idle code, underrun.
        frame_sync();
        bits(FB, 2);
        idle(3);

        // Full frame: slot i carries i.
        for (int i = 0; i < CH; i++) write(i, 8'(i));
        frame_sync();
        bits(FB, 4);
        idle(2);

        // Partial fill with back-to-back strobes.
        write(0, 8'hA5);
        write(31, 8'h3C);
        frame_sync();
        bits(FB, 1);
        idle(2);

        // Overwrite, then a write in the fs cycle belongs to the next frame.
        write(3, 8'h11);
        write(3, 8'h22);
        cycle(1'b1, 1'b0, 1'b1, 4, 8'h77);
        bits(FB, 2);
        idle(1);
        frame_sync();
        bits(FB, 1);
        idle(2);

        // Early fs, then fs colliding with bit_en.
        write(7, 8'h5A);
        frame_sync();
        bits(100, 2);
        frame_sync();
        bits(50, 1);
        cycle(1'b1, 1'b1, 1'b0, 0, '0);
        bits(FB, 1);
        idle(2);

        // Reset in the middle of a frame discards pending writes too.
        write(2, 8'h0F);
        frame_sync();
        bits(40, 1);
        write(9, 8'h12);
        reset = 1'b0;
        #1;
        chk_all_zero("async reset mid-frame");
        exp_q.delete();
        in_frame = 1'b0;
        pos = 0;
        pend_mask = '0;
        cur_bit = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("wr_ready after mid-frame reset", wr_if.wr_ready, 1'b0);
        frame_sync();
        bits(FB, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
